// File: rtl/memory_ctrl_pkg.sv
// Shared types and constants for the memory controller.
package memory_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF     = 8;
    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned MAX_RD_LATENCY = 4;
    // Wide enough to hold MAX_RD_LATENCY-1
    localparam int unsigned LAT_CNT_W      = $clog2(MAX_RD_LATENCY);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StRdWait,
        StDone
    } state_e;

endpackage

// File: rtl/memory_interface.sv
// Signal bundle between requester, controller and memory core.
// The bidirectional system data bus is a resolved net owned by whoever
// instantiates the bundle, so it is not carried here.
interface memory_interface #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input logic clk,
    input logic reset
);
    logic              cmd_valid_sys;
    logic              we_sys;
    logic [ADDR_W-1:0] addr_sys;
    logic              ready_sys;
    logic              we_mem;
    logic              ce_mem;
    logic [ADDR_W-1:0] addr_mem;
    logic [DATA_W-1:0] datai_mem;
    logic [DATA_W-1:0] datao_mem;

    modport ctrl_port (
        input  clk, reset, cmd_valid_sys, we_sys, addr_sys, datao_mem,
        output ready_sys, we_mem, ce_mem, addr_mem, datai_mem
    );
endinterface

// File: rtl/memory_ctrl.sv
// Memory controller: turns single system-bus read/write commands into
// one-cycle chip-enable accesses on the memory-core bus and acknowledges
// each with a one-cycle ready_sys pulse.
// Optional macro MEMORY_CTRL_STATS_EN adds saturating wr_count/rd_count.
module memory_ctrl
    import memory_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    // Legal range 1..MAX_RD_LATENCY
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_sys,
    input  logic              we_sys,
    input  logic [ADDR_W-1:0] addr_sys,
    inout  wire  [DATA_W-1:0] data_sys,
    output logic              ready_sys,
    output logic              we_mem,
    output logic              ce_mem,
    output logic [ADDR_W-1:0] addr_mem,
    output logic [DATA_W-1:0] datai_mem,
    input  logic [DATA_W-1:0] datao_mem
`ifdef MEMORY_CTRL_STATS_EN
    ,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
`endif
);

    state_e                 state;
    logic [LAT_CNT_W-1:0]   lat_cnt;
    logic [DATA_W-1:0]      rd_data;
    logic                   drive_en;
    logic                   is_rd;

    // Read data is presented only during the DONE cycle of a read
    assign data_sys = drive_en ? rd_data : {DATA_W{1'bz}};

    // Command FSM with registered memory-side and system-side outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            we_mem    <= 1'b0;
            ce_mem    <= 1'b0;
            ready_sys <= 1'b0;
            addr_mem  <= '0;
            datai_mem <= '0;
            rd_data   <= '0;
            lat_cnt   <= '0;
            drive_en  <= 1'b0;
            is_rd     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            we_mem    <= 1'b0;
            ce_mem    <= 1'b0;
            ready_sys <= 1'b0;
            drive_en  <= 1'b0;
            case (state)
                StIdle: begin
                    if (cmd_valid_sys) begin
                        addr_mem <= addr_sys;
                        ce_mem   <= 1'b1;
                        is_rd    <= !we_sys;
                        if (we_sys) begin
                            datai_mem <= data_sys;
                            we_mem    <= 1'b1;
                            state     <= StWrite;
                        end else begin
                            state <= StRead;
                        end
                    end
                end
                StWrite: begin
                    ready_sys <= 1'b1;
                    state     <= StDone;
                end
                StRead: begin
                    lat_cnt <= LAT_CNT_W'(RD_LATENCY - 1);
                    state   <= StRdWait;
                end
                StRdWait: begin
                    if (lat_cnt == '0) begin
                        rd_data   <= datao_mem;
                        ready_sys <= 1'b1;
                        drive_en  <= 1'b1;
                        state     <= StDone;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_CNT_W'(1);
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef MEMORY_CTRL_STATS_EN
    // Completed-command counters, bumped in DONE and saturating at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_count <= '0;
            rd_count <= '0;
        end else if (state == StDone) begin
            if (is_rd) begin
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end else begin
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_ctrl.sv
// Self-checking bench: two controllers (read latency 1 and 3), each with a
// behavioural memory core, checked against a reference memory and the
// command latency rules.
module tb_memory_ctrl;

    logic clk;
    logic reset;

    int n_checks;
    int n_pass;

    // Requester-side drive, indexed by instance (0: latency 1, 1: latency 3)
    logic       cmd_valid [2];
    logic       we_s      [2];
    logic [7:0] addr_s    [2];
    logic       drv_en    [2];
    logic [7:0] drv_d     [2];

    // Observed outputs
    logic       ready     [2];
    logic       ce        [2];
    logic       we_m      [2];
    logic [7:0] addr_m    [2];
    logic [7:0] datai     [2];
    logic [7:0] bus_v     [2];

    // Memory core model storage and read pipeline
    logic [7:0] core_mem  [2][256];
    logic [7:0] pipe      [2][4];

    // Reference contents as seen by the requester
    logic [7:0] ref_mem   [2][256];

    wire [7:0] bus_a;
    wire [7:0] bus_b;

    memory_interface #(.ADDR_W(8), .DATA_W(8)) mif_a (.clk(clk), .reset(reset));
    memory_interface #(.ADDR_W(8), .DATA_W(8)) mif_b (.clk(clk), .reset(reset));

    assign bus_a = drv_en[0] ? drv_d[0] : 8'hzz;
    assign bus_b = drv_en[1] ? drv_d[1] : 8'hzz;
    assign bus_v[0] = bus_a;
    assign bus_v[1] = bus_b;

    assign mif_a.cmd_valid_sys = cmd_valid[0];
    assign mif_a.we_sys        = we_s[0];
    assign mif_a.addr_sys      = addr_s[0];
    assign mif_a.datao_mem     = pipe[0][0];
    assign mif_b.cmd_valid_sys = cmd_valid[1];
    assign mif_b.we_sys        = we_s[1];
    assign mif_b.addr_sys      = addr_s[1];
    assign mif_b.datao_mem     = pipe[1][2];

    assign ready[0]  = mif_a.ready_sys;
    assign ce[0]     = mif_a.ce_mem;
    assign we_m[0]   = mif_a.we_mem;
    assign addr_m[0] = mif_a.addr_mem;
    assign datai[0]  = mif_a.datai_mem;
    assign ready[1]  = mif_b.ready_sys;
    assign ce[1]     = mif_b.ce_mem;
    assign we_m[1]   = mif_b.we_mem;
    assign addr_m[1] = mif_b.addr_mem;
    assign datai[1]  = mif_b.datai_mem;

    memory_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(1)) dut_a (
        .clk           (mif_a.clk),
        .reset         (mif_a.reset),
        .cmd_valid_sys (mif_a.cmd_valid_sys),
        .we_sys        (mif_a.we_sys),
        .addr_sys      (mif_a.addr_sys),
        .data_sys      (bus_a),
        .ready_sys     (mif_a.ready_sys),
        .we_mem        (mif_a.we_mem),
        .ce_mem        (mif_a.ce_mem),
        .addr_mem      (mif_a.addr_mem),
        .datai_mem     (mif_a.datai_mem),
        .datao_mem     (mif_a.datao_mem)
    );

    memory_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(3)) dut_b (
        .clk           (mif_b.clk),
        .reset         (mif_b.reset),
        .cmd_valid_sys (mif_b.cmd_valid_sys),
        .we_sys        (mif_b.we_sys),
        .addr_sys      (mif_b.addr_sys),
        .data_sys      (bus_b),
        .ready_sys     (mif_b.ready_sys),
        .we_mem        (mif_b.we_mem),
        .ce_mem        (mif_b.ce_mem),
        .addr_mem      (mif_b.addr_mem),
        .datai_mem     (mif_b.datai_mem),
        .datao_mem     (mif_b.datao_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory core: write on ce&we, read launched on ce&!we, data shifts
    // one stage per cycle so tap N-1 is valid N cycles after the access
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 3; j > 0; j--) pipe[i][j] <= pipe[i][j-1];
            if (ce[i] && !we_m[i]) pipe[i][0] <= core_mem[i][addr_m[i]];
            if (ce[i] && we_m[i]) core_mem[i][addr_m[i]] = datai[i];
        end
    end

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 1 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Issue one command in the current IDLE cycle and follow it to ready_sys.
    // Returns at the falling edge of the DONE cycle; with hold set,
    // cmd_valid stays high throughout the command.
    task automatic do_cmd(input int sel, input bit wr, input logic [7:0] a,
                          input logic [7:0] d, input bit hold);
        int         exp_lat;
        logic [7:0] exp_rd;
        exp_lat = wr ? 2 : 2 + lat_of(sel);
        exp_rd  = ref_mem[sel][a];
        if (wr) ref_mem[sel][a] = d;
        @(negedge clk);
        cmd_valid[sel] = 1'b1;
        we_s[sel]      = wr;
        addr_s[sel]    = a;
        drv_en[sel]    = wr;
        drv_d[sel]     = d;
        @(negedge clk);
        drv_en[sel] = 1'b0;
        if (!hold) cmd_valid[sel] = 1'b0;
        check_eq("ce_access", 32'(ce[sel]), 32'd1);
        check_eq("we_access", 32'(we_m[sel]), 32'(wr));
        check_eq("addr_mem", 32'(addr_m[sel]), 32'(a));
        if (wr) check_eq("datai_mem", 32'(datai[sel]), 32'(d));
        check_eq("ready_early", 32'(ready[sel]), 32'd0);
        for (int k = 2; k <= exp_lat; k++) begin
            @(negedge clk);
            check_eq("ce_single", 32'(ce[sel]), 32'd0);
            check_eq("ready_timing", 32'(ready[sel]), 32'(k == exp_lat));
            if (k == exp_lat && !wr) check_eq("rd_data", 32'(bus_v[sel]), 32'(exp_rd));
        end
    endtask

    // Spend one IDLE cycle: drop cmd_valid and confirm the bus is released
    // by driving zero against it
    task automatic check_release(input int sel);
        @(negedge clk);
        cmd_valid[sel] = 1'b0;
        drv_en[sel]    = 1'b1;
        drv_d[sel]     = 8'h00;
        #1;
        check_eq("bus_released", 32'(bus_v[sel]), 32'd0);
        check_eq("ready_idle", 32'(ready[sel]), 32'd0);
        check_eq("ce_idle", 32'(ce[sel]), 32'd0);
        drv_en[sel] = 1'b0;
    endtask

    // Start a read and pull reset after at_cycle cycles (1: READ, 2: RD_WAIT)
    task automatic reset_mid(input int sel, input int at_cycle);
        @(negedge clk);
        cmd_valid[sel] = 1'b1;
        we_s[sel]      = 1'b0;
        addr_s[sel]    = 8'($urandom);
        for (int k = 1; k <= at_cycle; k++) begin
            @(negedge clk);
            cmd_valid[sel] = 1'b0;
        end
        if (at_cycle == 1) check_eq("ce_before_rst", 32'(ce[sel]), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("ce_async_drop", 32'(ce[sel]), 32'd0);
        check_eq("we_async_drop", 32'(we_m[sel]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("no_ready_abort", 32'(ready[sel]), 32'd0);
            check_eq("ce_in_reset", 32'(ce[sel]), 32'd0);
        end
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("no_ready_after", 32'(ready[sel]), 32'd0);
            check_eq("ce_after_rst", 32'(ce[sel]), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 256; a++) begin
                core_mem[i][a] = 8'(a * 7 + i * 13);
                ref_mem[i][a]  = 8'(a * 7 + i * 13);
            end
            cmd_valid[i] = 1'b1;
            we_s[i]      = 1'(i);
            addr_s[i]    = 8'h22;
            drv_en[i]    = 1'b1;
            drv_d[i]     = 8'h00;
        end

        // Reset held with a pending command: nothing may happen
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check_eq("rst_ce", 32'(ce[i]), 32'd0);
                check_eq("rst_we", 32'(we_m[i]), 32'd0);
                check_eq("rst_ready", 32'(ready[i]), 32'd0);
                check_eq("rst_bus", 32'(bus_v[i]), 32'd0);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0;
            drv_en[i]    = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check_eq("post_rst_ce", 32'(ce[i]), 32'd0);
                check_eq("post_rst_ready", 32'(ready[i]), 32'd0);
            end
        end

        // Directed write and reads at both latencies
        do_cmd(0, 1'b1, 8'h3C, 8'hA5, 1'b0);
        do_cmd(0, 1'b1, 8'h10, 8'h5A, 1'b0);
        do_cmd(0, 1'b0, 8'h10, 8'h00, 1'b0);
        check_release(0);
        do_cmd(1, 1'b1, 8'hFF, 8'hC3, 1'b0);
        do_cmd(1, 1'b0, 8'hFF, 8'h00, 1'b0);
        check_release(1);

        // cmd_valid held high across alternating back-to-back commands
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 6; n++) begin
                do_cmd(i, 1'(n % 2 == 0), 8'(8'h40 + n / 2), 8'(8'h90 + n), 1'b1);
            end
            check_release(i);
        end

        // Randomized traffic over a small address window so reads hit writes
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 40; n++) begin
                do_cmd(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                       8'($urandom), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) check_release(i);
            end
            check_release(i);
        end

        // Reset during READ and during RD_WAIT, then normal operation again
        reset_mid(0, 1);
        do_cmd(0, 1'b0, 8'h3C, 8'h00, 1'b0);
        check_release(0);
        reset_mid(1, 2);
        do_cmd(1, 1'b0, 8'hFF, 8'h00, 1'b0);
        check_release(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/memory_ctrl.md
Name: memory_ctrl

Overview:
- Memory controller between the testcase/system side and the memory core.
- Accepts single read/write commands on the system bus and converts each into a one-cycle chip-enable access on the memory-core bus.
- Returns read data on the bidirectional system data bus and acknowledges completion of every command with a one-cycle `ready_sys` pulse.
- Implements the `ctrl_port` view of `memory_interface`; the memory core sits directly downstream.

Parameters:
- ADDR_W, 8, address width on both system and memory buses.
- DATA_W, 8, data width on both buses.
- RD_LATENCY, 1, cycles from the `ce_mem` read cycle until `datao_mem` is valid; legal range 1..4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid_sys  input  1  command request; sampled only in IDLE.
- we_sys  input  1  1 = write, 0 = read; qualified by `cmd_valid_sys`.
- addr_sys  input  ADDR_W  command address.
- data_sys  inout  DATA_W  write data in; read data out when driven, Z otherwise.
- ready_sys  output  1  one-cycle completion pulse.
- we_mem  output  1  memory write enable.
- ce_mem  output  1  memory chip enable.
- addr_mem  output  ADDR_W  memory address.
- datai_mem  output  DATA_W  memory write data.
- datao_mem  input  DATA_W  memory read data.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE. Outputs go to: `we_mem`=0, `ce_mem`=0, `ready_sys`=0, `addr_mem`=0, `datai_mem`=0, `data_sys` released to Z, latency counter=0.
- States: IDLE, WRITE, READ, RD_WAIT, DONE.
- IDLE, `cmd_valid_sys`=1:
  - Capture `addr_sys` into `addr_mem`.
  - If `we_sys`=1, capture `data_sys` into `datai_mem` and go to WRITE; else go to READ.
  - Without `cmd_valid_sys`, stay in IDLE.
- WRITE: `ce_mem`=1 and `we_mem`=1 for exactly one cycle, then go to DONE.
- READ: `ce_mem`=1 and `we_mem`=0 for exactly one cycle. Load counter with RD_LATENCY-1, then go to RD_WAIT.
- RD_WAIT: `ce_mem`=0. Decrement the counter each cycle. When the counter is 0, register `datao_mem` into the read-data register and go to DONE.
- DONE:
  - `ready_sys`=1 for one cycle.
  - For a read, `data_sys` is driven with the read-data register during this cycle only.
  - Go to IDLE.
- Latency from `cmd_valid_sys` sampled to `ready_sys`:
  - Write: 2 cycles.
  - Read: 2+RD_LATENCY cycles (3 at default).
- Exactly one command is outstanding at a time. `cmd_valid_sys` is ignored outside IDLE; the requester must not assert it again before seeing `ready_sys`.
- The earliest new command is accepted in the cycle after `ready_sys` (IDLE).
- `addr_mem` and `datai_mem` hold their last values between commands. `ce_mem` and `we_mem` are never X after reset.
- `data_sys` is never driven except during a read DONE, so there is no bus contention when the requester drives write data.
- Reset mid-operation: the access is aborted immediately and `ce_mem`/`we_mem` drop asynchronously. No `ready_sys` is issued for the aborted command.
- Address/data wrap at ADDR_W/DATA_W; no arithmetic is performed on them.

Optional Feature:
- Macro: MEMORY_CTRL_STATS_EN.
- With the macro defined:
  - Adds outputs `wr_count` and `rd_count`, each 16 bits.
  - Each counter increments in the DONE cycle of its command type and saturates at 16'hFFFF.
  - Both are cleared by reset.
- Without the macro: these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Package `memory_ctrl_pkg` holds:
  - the state enum typedef (IDLE, WRITE, READ, RD_WAIT, DONE);
  - the ADDR_W/DATA_W default constants;
  - localparam MAX_RD_LATENCY=4.
- No sub-module: the FSM, latency counter and tri-state driver stay in one module.
- The bench connects the block through `memory_interface.ctrl_port`.

Test Plan:
- Reset: hold `reset`=0 for 3 cycles with `cmd_valid_sys`=1, then release. Expect `ce_mem`=`we_mem`=`ready_sys`=0 throughout reset, `data_sys`=Z, and no spurious access.
- Write: `cmd_valid_sys`=1, `we_sys`=1, `addr_sys`=8'h3C, `data_sys`=8'hA5. Next cycle expect `ce_mem`=`we_mem`=1, `addr_mem`=8'h3C, `datai_mem`=8'hA5. Expect `ready_sys`=1 two cycles after sampling.
- Read at RD_LATENCY=1: write 8'h5A to 8'h10, then read 8'h10. Expect `ce_mem`=1/`we_mem`=0 for one cycle, then `ready_sys`=1 with `data_sys`=8'h5A three cycles after sampling, and `data_sys`=Z the next cycle.
- Read at RD_LATENCY=3: read 8'hFF after writing 8'hC3. Expect `ready_sys` exactly 5 cycles after sampling with `data_sys`=8'hC3.
- Protocol: hold `cmd_valid_sys`=1 continuously over alternating write/read commands. Expect one access per `ready_sys`, the next command accepted the cycle after `ready_sys`, and no double `ce_mem`.
- Reset mid-read: assert `reset` during RD_WAIT. Expect `ce_mem`=0 immediately, no `ready_sys`, IDLE after release. With MEMORY_CTRL_STATS_EN, `rd_count`=0.
